// File: rtl/fp32_pkg.sv
// Shared single-precision constants, flag indices and the adder-to-normalizer
// raw-sum bundle used by floating_point_addition and fp_normalize_round.
package fp32_pkg;

  localparam int EXPO_W   = 8;
  localparam int MENT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef struct packed {
    logic              sign;
    logic [EXPO_W:0]   exp;
    logic [MENT_W+4:0] mant;
    logic              nan;
    logic              inf;
  } raw_sum_t;

  typedef enum logic [1:0] {
    KIND_FINITE = 2'd0,
    KIND_ZERO   = 2'd1,
    KIND_INF    = 2'd2,
    KIND_NAN    = 2'd3
  } val_kind_e;

  // NaN dominates infinity, which dominates an all-zero mantissa.
  function automatic val_kind_e classify(input logic nan, input logic inf, input logic zero);
    if (nan) begin
      classify = KIND_NAN;
    end else if (inf) begin
      classify = KIND_INF;
    end else if (zero) begin
      classify = KIND_ZERO;
    end else begin
      classify = KIND_FINITE;
    end
  endfunction

endpackage

// File: rtl/fp_leading_zero_count.sv
// Parameterized combinational leading-zero counter; an all-zero vector
// reports WIDTH.
module fp_leading_zero_count #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CW-1:0]    count
);

  // Scan upward so the most significant set bit is the last to overwrite.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      count = vec[i] ? CW'(WIDTH - 1 - i) : count;
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Three-stage normalize / round-to-nearest-even / pack stage after the FP adder.
// Build option: define FP_NORM_FTZ_EN to flush tiny results to signed zero.
module fp_normalize_round
  import fp32_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXPO_WIDTH:0]   in_exp,
  input  logic [MENT_WIDTH+4:0] in_mant,
  input  logic                  in_nan,
  input  logic                  in_inf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            out_flags
);

  localparam int MW  = MENT_WIDTH + 5;
  localparam int NW  = MENT_WIDTH + 4;
  localparam int SGW = MENT_WIDTH + 2;
  localparam int XW  = EXPO_WIDTH + 2;
  localparam int LZW = $clog2(NW + 1);
  localparam logic [XW-1:0] EXP_TOP = XW'((1 << EXPO_WIDTH) - 1);

`ifdef FP_NORM_FTZ_EN
  localparam logic FTZ = 1'b1;
`else
  localparam logic FTZ = 1'b0;
`endif

  logic                  adv;
  logic [LZW-1:0]        lz_count;

  logic                  s1_valid;
  logic                  s1_sign;
  logic [EXPO_WIDTH:0]   s1_exp;
  logic [MW-1:0]         s1_mant;
  logic [LZW-1:0]        s1_lz;
  val_kind_e             s1_kind;

  logic [NW-1:0]         norm_mant;
  logic [XW-1:0]         norm_exp;
  logic [XW-1:0]         sh_lim;
  logic [XW-1:0]         sh;

  logic                  s2_valid;
  logic                  s2_sign;
  val_kind_e             s2_kind;
  logic [XW-1:0]         s2_exp;
  logic [NW-1:0]         s2_mant;

  logic                  s3_valid;

  logic                  g_bit;
  logic                  r_bit;
  logic                  s_bit;
  logic                  lsb;
  logic                  inexact;
  logic                  tiny;
  logic                  inc;
  logic [SGW-1:0]        sig_rnd;
  logic [XW-1:0]         exp_rnd;
  logic                  hidden_rnd;
  logic [EXPO_WIDTH-1:0] exp_field;
  logic [DATA_WIDTH-1:0] inf_word;
  logic [DATA_WIDTH-1:0] nan_word;
  logic [DATA_WIDTH-1:0] res_data;
  logic [3:0]            res_flags;

  assign adv       = !s3_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = s3_valid;

  fp_leading_zero_count #(
    .WIDTH (NW),
    .CW    (LZW)
  ) u_lzc (
    .vec   (in_mant[NW-1:0]),
    .count (lz_count)
  );

  // Normalize: a carry shifts right with sticky folding, otherwise shift left
  // no further than the minimum normal exponent so tiny values stay subnormal.
  always_comb begin
    sh_lim    = '0;
    sh        = '0;
    norm_mant = s1_mant[NW-1:0];
    norm_exp  = {1'b0, s1_exp};
    if (s1_mant[MW-1]) begin
      norm_mant = {s1_mant[MW-1:2], s1_mant[1] | s1_mant[0]};
      norm_exp  = {1'b0, s1_exp} + XW'(1);
    end else begin
      sh_lim    = (s1_exp == '0) ? '0 : ({1'b0, s1_exp} - XW'(1));
      sh        = (XW'(s1_lz) < sh_lim) ? XW'(s1_lz) : sh_lim;
      norm_mant = s1_mant[NW-1:0] << sh;
      norm_exp  = {1'b0, s1_exp} - sh;
    end
  end

  // Round to nearest even and pack; specials and overflow override the finite path.
  always_comb begin
    g_bit      = s2_mant[2];
    r_bit      = s2_mant[1];
    s_bit      = s2_mant[0];
    lsb        = s2_mant[3];
    inexact    = g_bit | r_bit | s_bit;
    tiny       = ~s2_mant[NW-1];
    inc        = g_bit & (r_bit | s_bit | lsb);
    sig_rnd    = SGW'(s2_mant[NW-1:3]) + SGW'(inc);
    exp_rnd    = s2_exp + XW'(sig_rnd[SGW-1]);
    hidden_rnd = sig_rnd[SGW-1] | sig_rnd[SGW-2];
    exp_field  = hidden_rnd ? exp_rnd[EXPO_WIDTH-1:0] : '0;
    inf_word   = {s2_sign, {EXPO_WIDTH{1'b1}}, {MENT_WIDTH{1'b0}}};
    nan_word   = {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MENT_WIDTH-1){1'b0}}};
    res_data   = '0;
    res_flags  = '0;
    case (s2_kind)
      KIND_NAN: begin
        res_data                = nan_word;
        res_flags[FLAG_INVALID] = 1'b1;
      end
      KIND_INF: begin
        res_data = inf_word;
      end
      KIND_ZERO: begin
        res_data = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
      end
      KIND_FINITE: begin
        if (FTZ && tiny) begin
          res_data                  = {s2_sign, {(DATA_WIDTH-1){1'b0}}};
          res_flags[FLAG_UNDERFLOW] = 1'b1;
          res_flags[FLAG_INEXACT]   = 1'b1;
        end else if (hidden_rnd && (exp_rnd >= EXP_TOP)) begin
          res_data                 = inf_word;
          res_flags[FLAG_OVERFLOW] = 1'b1;
          res_flags[FLAG_INEXACT]  = 1'b1;
        end else begin
          res_data                  = {s2_sign, exp_field, sig_rnd[MENT_WIDTH-1:0]};
          res_flags[FLAG_UNDERFLOW] = tiny & inexact;
          res_flags[FLAG_INEXACT]   = inexact;
        end
      end
      default: begin
        res_data  = '0;
        res_flags = '0;
      end
    endcase
  end

  // Pipeline registers: every stage moves together on adv, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_exp    <= '0;
      s1_mant   <= '0;
      s1_lz     <= '0;
      s1_kind   <= KIND_FINITE;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_kind   <= KIND_FINITE;
      s2_exp    <= '0;
      s2_mant   <= '0;
      s3_valid  <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_sign;
      s1_exp    <= in_exp;
      s1_mant   <= in_mant;
      s1_lz     <= lz_count;
      s1_kind   <= classify(in_nan, in_inf, in_mant == '0);
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_kind   <= s1_kind;
      s2_exp    <= norm_exp;
      s2_mant   <= norm_mant;
      s3_valid  <= s2_valid;
      out_data  <= s2_valid ? res_data : '0;
      out_flags <= s2_valid ? res_flags : 4'b0000;
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Self-checking bench for fp_normalize_round: directed vector table, latency,
// backpressure and reset sequences, then randomized traffic against a value model.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [8:0]  in_exp = 9'd0;
  logic [27:0] in_mant = 28'd0;
  logic        in_nan = 1'b0;
  logic        in_inf = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef FP_NORM_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  typedef struct {
    logic        sign;
    logic [8:0]  e;
    logic [27:0] m;
    logic        nan;
    logic        inf;
    logic [31:0] data;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[16];
  logic [35:0] expq[$];

  fp_normalize_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .in_nan    (in_nan),
    .in_inf    (in_inf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Exact value M * 2^(E-127-26), rounded to nearest-even into binary32.
  function automatic logic [35:0] model(input logic sign, input int e, input logic [27:0] m,
                                        input logic nan, input logic inf);
    int p, e_lead, base, d;
    longint q, rem, half;
    logic inexact, tiny;
    if (nan) return {32'h7FC0_0000, 4'b1000};
    if (inf) return {sign, 31'h7F80_0000, 4'b0000};
    if (m == 28'd0) return {sign, 31'd0, 4'b0000};
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    e_lead = e - 26 + p;
    tiny   = (e_lead < 1);
    base   = tiny ? 1 : e_lead;
    d      = p - 23 + (base - e_lead);
    rem    = 0;
    q      = longint'(m);
    if (d <= 0) begin
      q = q << (-d);
    end else begin
      rem  = q & ((longint'(1) << d) - 1);
      half = longint'(1) << (d - 1);
      q    = q >> d;
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    end
    inexact = (rem != 0);
    if (q >= (longint'(1) << 24)) begin
      q    = q >> 1;
      base = base + 1;
    end
    if (FTZ && tiny) return {sign, 31'd0, 4'b0011};
    if (q >= (longint'(1) << 23) && base >= 255) return {sign, 31'h7F80_0000, 4'b0101};
    if (q >= (longint'(1) << 23))
      return {sign, 8'(base), 23'(q), 2'b00, tiny & inexact, inexact};
    return {sign, 8'd0, 23'(q), 2'b00, tiny & inexact, inexact};
  endfunction

  task automatic rand_input();
    logic [31:0] t;
    int w, sel;
    t       = $urandom;
    w       = $urandom_range(0, 28);
    in_mant = t[27:0] >> (28 - w);
    sel     = $urandom_range(0, 3);
    in_exp  = (sel == 0) ? 9'($urandom_range(1, 30)) :
              (sel == 1) ? 9'($urandom_range(240, 300)) : 9'($urandom_range(1, 511));
    in_sign = 1'($urandom_range(0, 1));
    in_nan  = ($urandom_range(0, 15) == 0);
    in_inf  = ($urandom_range(0, 15) == 0);
  endtask

  task automatic set_bp(input int i);
    in_sign = 1'b0;
    in_exp  = 9'(127 + i);
    in_mant = 28'h400_0000;
    in_nan  = 1'b0;
    in_inf  = 1'b0;
  endtask

  task automatic apply_vec(input int i);
    int n;
    @(negedge clk);
    in_sign   = vecs[i].sign;
    in_exp    = vecs[i].e;
    in_mant   = vecs[i].m;
    in_nan    = vecs[i].nan;
    in_inf    = vecs[i].inf;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check($sformatf("vec%0d latency", i), 32'(n), 32'd3);
    check($sformatf("vec%0d data", i), out_data, vecs[i].data);
    check($sformatf("vec%0d flags", i), 32'(out_flags), 32'(vecs[i].flags));
  endtask

  initial begin
    int  idx, got, stale;
    bit  acc, hold, stalled;
    logic [31:0] prev_data;
    logic [3:0]  prev_flags;
    logic [35:0] e;

    vecs[0]  = '{1'b0, 9'd127, 28'h800_0000, 1'b0, 1'b0, 32'h4000_0000, 4'b0000};
    vecs[1]  = '{1'b0, 9'd130, 28'h080_0000, 1'b0, 1'b0, 32'h3F80_0000, 4'b0000};
    vecs[2]  = '{1'b1, 9'd5,   28'h000_0000, 1'b0, 1'b0, 32'h8000_0000, 4'b0000};
    vecs[3]  = '{1'b0, 9'd127, 28'h7FF_FFFC, 1'b0, 1'b0, 32'h4000_0000, 4'b0001};
    vecs[4]  = '{1'b0, 9'd127, 28'h400_0004, 1'b0, 1'b0, 32'h3F80_0000, 4'b0001};
    vecs[5]  = '{1'b0, 9'd254, 28'h800_0000, 1'b0, 1'b0, 32'h7F80_0000, 4'b0101};
    vecs[6]  = '{1'b0, 9'd100, 28'h400_0000, 1'b1, 1'b0, 32'h7FC0_0000, 4'b1000};
    vecs[7]  = '{1'b1, 9'd100, 28'h400_0000, 1'b0, 1'b1, 32'hFF80_0000, 4'b0000};
    vecs[8]  = '{1'b1, 9'd100, 28'h400_0000, 1'b1, 1'b1, 32'h7FC0_0000, 4'b1000};
    vecs[9]  = '{1'b0, 9'd1,   28'h000_0008, 1'b0, 1'b0,
                 FTZ ? 32'h0000_0000 : 32'h0000_0001, FTZ ? 4'b0011 : 4'b0000};
    vecs[10] = '{1'b0, 9'd1,   28'h000_000C, 1'b0, 1'b0,
                 FTZ ? 32'h0000_0000 : 32'h0000_0002, 4'b0011};
    vecs[11] = '{1'b0, 9'd1,   28'h3FF_FFFC, 1'b0, 1'b0,
                 FTZ ? 32'h0000_0000 : 32'h0080_0000, 4'b0011};
    vecs[12] = '{1'b1, 9'd127, 28'h600_0000, 1'b0, 1'b0, 32'hBFC0_0000, 4'b0000};
    vecs[13] = '{1'b0, 9'd127, 28'h800_0004, 1'b0, 1'b0, 32'h4000_0000, 4'b0001};
    vecs[14] = '{1'b0, 9'd127, 28'h400_000C, 1'b0, 1'b0, 32'h3F80_0002, 4'b0001};
    vecs[15] = '{1'b1, 9'd3,   28'h000_0400, 1'b0, 1'b0,
                 FTZ ? 32'h8000_0000 : 32'h8000_0200, FTZ ? 4'b0011 : 4'b0000};

    #1 rst = 1'b1;
    #2;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_data", out_data, 32'd0);
    check("reset out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) apply_vec(i);

    // Backpressure: five offers while the sink stalls for six cycles.
    @(negedge clk);
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 5) begin in_valid = 1'b1; set_bp(idx); end else in_valid = 1'b0;
      #1;
      if (c == 5) check("bp in_ready held low", 32'(in_ready), 32'd0);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    check("bp accepted while stalled", 32'(idx), 32'd3);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (idx < 5) begin in_valid = 1'b1; set_bp(idx); end else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        check($sformatf("bp out%0d", got), out_data, 32'((127 + got) << 23));
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp output count", 32'(got), 32'd5);

    // Reset with data in flight and a result waiting.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      set_bp(c + 10);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    check("mid reset out_data", out_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) stale++;
      @(posedge clk);
      @(negedge clk);
    end
    check("no stale output after reset", 32'(stale), 32'd0);

    // Random traffic with random backpressure against the value model.
    hold = 1'b0;
    stalled = 1'b0;
    prev_data = '0;
    prev_flags = '0;
    for (int c = 0; c < 800; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_input();
      end
      #1;
      if (stalled) begin
        check("stall out_valid", 32'(out_valid), 32'd1);
        check("stall out_data", out_data, prev_data);
        check("stall out_flags", 32'(out_flags), 32'(prev_flags));
      end
      if (out_valid && out_ready) begin
        check("rand scoreboard nonempty", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          check("rand data", out_data, e[35:4]);
          check("rand flags", 32'(out_flags), 32'(e[3:0]));
        end
      end
      stalled    = out_valid && !out_ready;
      prev_data  = out_data;
      prev_flags = out_flags;
      acc = in_valid && in_ready;
      if (acc) expq.push_back(model(in_sign, int'(in_exp), in_mant, in_nan, in_inf));
      @(posedge clk);
      @(negedge clk);
      hold = in_valid && !acc;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && expq.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        e = expq.pop_front();
        check("drain data", out_data, e[35:4]);
        check("drain flags", 32'(out_flags), 32'(e[3:0]));
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("drain scoreboard empty", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Post-adder normalize/round stage for the single-precision FP datapath. Sits directly downstream of floating_point_addition.
- Consumes the adder's unnormalized raw sum: sign, extended exponent, wide mantissa with guard/round/sticky.
- Produces a packed IEEE-754 result plus exception flags.
- 3-stage valid/ready pipeline: leading-zero count -> shift/exponent adjust -> round/pack.

Parameters:
DATA_WIDTH, 32, packed result width
MENT_WIDTH, 23, stored fraction bits
EXPO_WIDTH, 8, exponent field bits

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  raw sum valid
in_ready  output  1  stage accepts input this cycle
in_sign  input  1  result sign
in_exp  input  EXPO_WIDTH+1  biased exponent of hidden-bit position (>=1 for finite values)
in_mant  input  MENT_WIDTH+5  [27]=carry, [26]=hidden, [25:3]=fraction, [2]=G, [1]=R, [0]=S
in_nan  input  1  result is NaN
in_inf  input  1  result is infinity (sign from in_sign)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DATA_WIDTH  packed {sign, exponent, fraction}
out_flags  output  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset, asynchronous, active-high: all stage valid bits 0. out_valid=0, out_data=0, out_flags=0, in_ready=1. A reset mid-operation discards all in-flight data.
- Advance rule: adv = !s3_valid || out_ready; in_ready = adv.
  - When adv=1, every stage register loads from its predecessor, bubbles included.
  - When adv=0, all stages hold.
  - Latency is exactly 3 cycles from an accepted input to out_valid with no stall. One result per cycle sustained.
- Stage 1, S1:
  - Register inputs.
  - Compute lz = leading zeros of in_mant[26:0] counted from bit 26 (0..27).
  - Compute zero = (in_mant==0).
- Stage 2, S2 (normalize):
  - If mant[27]=1: shift right 1, fold the shifted-out bit into S, exp+1.
  - Else if zero: result is signed zero with in_sign.
  - Else: sh = min(lz, exp-1); shift left by sh; exp -= sh. The result is subnormal (tiny) when the final hidden bit=0, with exponent field 0.
- Stage 3, S3 (round, RNE):
  - inc = G & (R | S | lsb). Fraction + inc; a carry out of the hidden bit gives exp+1. A subnormal rounding up into the hidden bit becomes exponent field 1.
  - inexact = G|R|S.
  - If exp >= 2^EXPO_WIDTH-1: output ±inf (0x7F800000 | sign), set overflow and inexact.
  - underflow = tiny-before-round & inexact.
- Specials override all of the above:
  - in_nan: output 0x7FC00000, invalid=1, other flags 0.
  - in_inf: output sign|0x7F800000, all flags 0.
  - If both are set, NaN wins.
- out_flags are only meaningful while out_valid=1. Outputs hold stable while out_valid & !out_ready.

Optional Feature:
- Macro: FP_NORM_FTZ_EN.
  - Defined: any tiny result (pre-round hidden bit 0, nonzero) outputs signed zero with underflow=1 and inexact=1; subnormal rounding logic is bypassed.
  - Undefined: full gradual-underflow behaviour as above.

Decomposition:
- Shared package fp32_pkg:
  - Width and bias constants: EXP_BIAS=127, EXP_MAX=255.
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000.
  - Flag bit index constants.
  - Raw-sum struct typedef {sign, exp, mant, nan, inf}, shared with floating_point_addition.
- One natural sub-module: fp_leading_zero_count, a parameterized combinational LZC used in S1.

Test Plan:
- Carry normalize: exp=127, mant=0x8000000 -> out_data=0x40000000, flags=0, out_valid exactly 3 cycles after accept.
- Cancellation: exp=130, mant=0x0800000 (bit 23 only, lz=3) -> 0x3F800000, flags=0. Also exp=5, mant=0, sign=1 -> 0x80000000.
- RNE carry-through: exp=127, mant=0x7FFFFFC -> 0x40000000, inexact=1. Tie-to-even: mant=0x4000004 (lsb=0, G=1) -> 0x3F800000, inexact=1.
- Overflow: exp=254, mant=0x8000000 -> 0x7F800000, overflow=1, inexact=1. in_nan=1 -> 0x7FC00000, invalid=1.
- Subnormal: exp=1, mant=0x0000008 -> 0x00000001, underflow=0. With FP_NORM_FTZ_EN, exp=1, mant=0x000000C -> 0x00000000, underflow=1, inexact=1.
- Backpressure and reset: offer 5 back-to-back inputs with out_ready=0 for 6 cycles -> in_ready drops after 3 held, no loss, in-order outputs. Assert rst with 2 in flight -> out_valid=0 immediately, in_ready=1, no stale output after release.
